cosim_commit_queue: RTL
=======================

# cosim_commit_queue

Captures architectural commit events and external-interrupt (mip) changes from the RTL core, timestamps them with a retirement sequence number, and buffers them in order for the co-simulation checker. The checker pops records one at a time over a valid/ready handshake and replays each against the Spike golden model: commit records through step/get_spike_commit_info, interrupt records through spike_set_external_interrupt. One instance per hart sits beside the core in the MEEP_COSIM bench; it never stalls the core, but it exposes an almost-full hint and a sticky overflow flag.

## Interface
- DEPTH, 16, queue entries; power of two, minimum 4.
- AFULL_MARGIN, 2, almost_full_o asserts when free entries <= AFULL_MARGIN.
- HART_ID, 0, hart tag copied into every record.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- commit_valid_i  in  1  one instruction retires this cycle.
- commit_pc_i  in  64  PC of the retiring instruction.
- commit_ins_i  in  32  instruction bits.
- commit_dst_i  in  5  destination register index.
- commit_wr_valid_i  in  1  register write performed.
- commit_data_i  in  64  write data.
- commit_xcpt_i  in  1  instruction trapped.
- commit_cause_i  in  64  trap cause.
- mip_i  in  64  current mip value from the core CSR file.
- out_valid_o  out  1  head record valid.
- out_ready_i  in  1  checker accepts the head record.
- out_kind_o  out  1  0 = commit record, 1 = interrupt record.
- out_hart_o  out  32  HART_ID.
- out_seq_o  out  32  retirement sequence number.
- out_pc_o, out_ins_o, out_dst_o, out_wr_valid_o, out_data_o, out_xcpt_o, out_cause_o  out  64/32/5/1/64/1/64  head record fields.
- almost_full_o  out  1  free-space hint.
- overflow_o  out  1  sticky: at least one record dropped.
- drop_cnt_o  out  16  dropped-cycle counter, saturating at 0xFFFF.

## Operation
- Interrupt event: mip_i != mip_q, where mip_q is a register reset to 0 and updated to mip_i every cycle.
- Interrupt record fields: kind=1, data=mip_i, seq = current seq_cnt (the sequence number of the next commit). All other fields are 0.
- Commit record fields: kind=0, the commit_* fields as presented, seq = seq_cnt. seq_cnt then increments by 1, wrapping modulo 2^32.
- Push count per cycle: 0, 1 or 2. If an interrupt event and a commit coincide, the interrupt record is written first, then the commit record, both in the same cycle.
- Space check: free = DEPTH - count + pop, where pop = out_valid_o & out_ready_i.
- If pushes > free, none of this cycle's records are written. Then:
  - overflow_o is set.
  - drop_cnt_o increments by 1 (saturating).
  - seq_cnt is still advanced if a commit occurred, so the checker sees a sequence gap.
  - mip_q is still updated.
- Pop removes the head entry. count = count + pushes - pop.
- Storage: circular buffer with write and read pointers of log2(DEPTH) bits, wrapping naturally. A second push writes at wptr+1.
- overflow_o and drop_cnt_o clear only on reset.
- almost_full_o = (DEPTH - count) <= AFULL_MARGIN, computed on the registered count.

## Timing
- Reset values: all outputs 0, count=0, pointers=0, seq_cnt=0, mip_q=0.
- Reset mid-operation discards all queued records immediately.
- Latency: a record pushed at edge N is visible on out_* after edge N with out_valid_o=1, i.e. usable in cycle N+1.
- Head fields are read directly from storage at rptr and are stable while out_valid_o=1 and out_ready_i=0.
- out_valid_o = (count != 0), driven from a register.
- Simultaneous push and pop on a full queue: the pop frees a slot usable in the same cycle, so a single push succeeds.
- A nonzero mip_i in the first cycle after reset generates an interrupt record.

## Test plan
- Single commit (pc=0x80000000, ins=0x00A00513, dst=10, data=0xA, wr_valid=1), ready high -> out_valid_o=1 next cycle with those fields, seq=0; queue empty the cycle after.
- mip_i goes 0 -> 0x800 in the same cycle as a commit with pc=0x80000004 -> first pop kind=1, data=0x800, seq=1; second pop kind=0, pc=0x80000004, seq=1; third commit carries seq=2.
- DEPTH=16, ready low, 16 commits -> almost_full_o=1 at count 14; the 17th commit is dropped, overflow_o=1, drop_cnt_o=1; draining shows seq 0..15 and the next commit has seq=17.
- Full queue, ready high, one commit -> accepted, count stays 16, no overflow.
- 20 commits with ready toggling every cycle -> every record delivered in order with contiguous seq and no duplication. Then assert rst_i mid-stream -> out_valid_o=0 and seq restarts at 0.

Source files
------------

// File: rtl/cosim_commit_queue.sv
// cosim_commit_queue: in-order commit/interrupt record FIFO for the cosim checker (commit_*/mip_i in, out_* valid/ready head record, almost_full_o/overflow_o/drop_cnt_o status)
module cosim_commit_queue #(
  parameter int          DEPTH        = 16,
  parameter int          AFULL_MARGIN = 2,
  parameter logic [31:0] HART_ID      = 32'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        commit_valid_i,
  input  logic [63:0] commit_pc_i,
  input  logic [31:0] commit_ins_i,
  input  logic [4:0]  commit_dst_i,
  input  logic        commit_wr_valid_i,
  input  logic [63:0] commit_data_i,
  input  logic        commit_xcpt_i,
  input  logic [63:0] commit_cause_i,
  input  logic [63:0] mip_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_kind_o,
  output logic [31:0] out_hart_o,
  output logic [31:0] out_seq_o,
  output logic [63:0] out_pc_o,
  output logic [31:0] out_ins_o,
  output logic [4:0]  out_dst_o,
  output logic        out_wr_valid_o,
  output logic [63:0] out_data_o,
  output logic        out_xcpt_o,
  output logic [63:0] out_cause_o,
  output logic        almost_full_o,
  output logic        overflow_o,
  output logic [15:0] drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic        kind;
    logic [31:0] hart;
    logic [31:0] seq;
    logic [63:0] pc;
    logic [31:0] ins;
    logic [4:0]  dst;
    logic        wr_valid;
    logic [63:0] data;
    logic        xcpt;
    logic [63:0] cause;
  } rec_t;
  rec_t          mem [DEPTH];
  rec_t          irq_rec, com_rec;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_nx;
  logic [AW+1:0] free;
  logic [31:0]   seq_cnt;
  logic [63:0]   mip_q;
  logic [1:0]    pushes, pushes_ok;
  logic          irq, pop, fit;
  assign irq       = mip_i != mip_q;
  assign pushes    = {1'b0, irq} + {1'b0, commit_valid_i};
  assign pop       = out_valid_o & out_ready_i;
  assign free      = (AW+2)'(DEPTH) - {1'b0, count} + (AW+2)'(pop);
  assign fit       = (AW+2)'(pushes) <= free;
  assign pushes_ok = fit ? pushes : 2'd0;
  assign count_nx  = count + (AW+1)'(pushes_ok) - (AW+1)'(pop);
  always_comb begin
    irq_rec      = '0;
    irq_rec.kind = 1'b1;
    irq_rec.hart = HART_ID;
    irq_rec.seq  = seq_cnt;
    irq_rec.data = mip_i;
    com_rec      = '{kind: 1'b0, hart: HART_ID, seq: seq_cnt, pc: commit_pc_i, ins: commit_ins_i,
                     dst: commit_dst_i, wr_valid: commit_wr_valid_i, data: commit_data_i,
                     xcpt: commit_xcpt_i, cause: commit_cause_i};
  end
  assign out_kind_o     = mem[rptr].kind;
  assign out_hart_o     = mem[rptr].hart;
  assign out_seq_o      = mem[rptr].seq;
  assign out_pc_o       = mem[rptr].pc;
  assign out_ins_o      = mem[rptr].ins;
  assign out_dst_o      = mem[rptr].dst;
  assign out_wr_valid_o = mem[rptr].wr_valid;
  assign out_data_o     = mem[rptr].data;
  assign out_xcpt_o     = mem[rptr].xcpt;
  assign out_cause_o    = mem[rptr].cause;
  assign almost_full_o  = ((AW+1)'(DEPTH) - count) <= (AW+1)'(AFULL_MARGIN);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      seq_cnt     <= '0;
      mip_q       <= '0;
      out_valid_o <= 1'b0;
      overflow_o  <= 1'b0;
      drop_cnt_o  <= '0;
    end else begin
      mip_q       <= mip_i;
      seq_cnt     <= seq_cnt + 32'(commit_valid_i);
      count       <= count_nx;
      out_valid_o <= count_nx != '0;
      rptr        <= rptr + AW'(pop);
      if (fit) begin
        if (irq) mem[wptr] <= irq_rec;
        if (commit_valid_i) mem[wptr + AW'(irq)] <= com_rec;
        wptr <= wptr + AW'(pushes);
      end else begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
      end
    end
  end
endmodule
